// File: rtl/hazard_ctrl.sv
// Hazard controller for the OTTER 5-stage pipeline: per-stage stall/flush,
// EX-stage forwarding selects, cache-miss wait FSM and a saturating stall counter.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [4:0]       rs1_addr_D,
  input  logic [4:0]       rs2_addr_D,
  input  logic [4:0]       rs1_addr_E,
  input  logic [4:0]       rs2_addr_E,
  input  logic [4:0]       rd_E,
  input  logic [4:0]       rd_M,
  input  logic [4:0]       rd_W,
  input  logic             regWrite_E,
  input  logic             regWrite_M,
  input  logic             regWrite_W,
  input  logic             memRead2_E,
  input  logic             pc_taken_E,
  input  logic             imem_miss,
  input  logic             imem_ready,
  input  logic             dmem_miss,
  input  logic             dmem_ready,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_M,
  output logic             flush_W,
  output logic [1:0]       fwdA_E,
  output logic [1:0]       fwdB_E,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IWAIT = 2'd1,
    DWAIT = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             load_use;

  assign load_use = memRead2_E && regWrite_E && (rd_E != 5'd0) &&
                    ((rd_E == rs1_addr_D) || (rd_E == rs2_addr_D));

  assign stall_cycles = stall_cnt_q;
  assign dbg_state    = state_q;

  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    stall_E = 1'b0;
    stall_M = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    flush_M = 1'b0;
    flush_W = 1'b0;
    fwdA_E  = 2'b00;
    fwdB_E  = 2'b00;
    if (!RST_N) begin
      // Reset drains every pipeline register regardless of what is in flight.
      flush_D = 1'b1;
      flush_E = 1'b1;
      flush_M = 1'b1;
      flush_W = 1'b1;
    end else begin
      if (regWrite_M && (rd_M != 5'd0) && (rd_M == rs1_addr_E))      fwdA_E = 2'b10;
      else if (regWrite_W && (rd_W != 5'd0) && (rd_W == rs1_addr_E)) fwdA_E = 2'b01;
      if (regWrite_M && (rd_M != 5'd0) && (rd_M == rs2_addr_E))      fwdB_E = 2'b10;
      else if (regWrite_W && (rd_W != 5'd0) && (rd_W == rs2_addr_E)) fwdB_E = 2'b01;
      case (state_q)
        DWAIT: begin
          stall_F = 1'b1;
          stall_D = 1'b1;
          stall_E = 1'b1;
          stall_M = 1'b1;
          flush_W = 1'b1;
        end
        IWAIT: begin
          stall_F = 1'b1;
          // A resolved branch is parked in E so its redirect lands after the fill.
          if (pc_taken_E) begin
            stall_D = 1'b1;
            stall_E = 1'b1;
            flush_M = 1'b1;
          end else begin
            flush_D = 1'b1;
          end
        end
        default: begin
          if (pc_taken_E) begin
            flush_D = 1'b1;
            flush_E = 1'b1;
          end else if (load_use) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
          end
        end
      endcase
    end
  end

  // Cache handshake: *_miss is a level held for the whole fill; *_ready is a
  // single-cycle pulse marking the last wait cycle, after which flow resumes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      if (stall_F && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      case (state_q)
        RUN: begin
          if (dmem_miss)      state_q <= DWAIT;
          else if (imem_miss) state_q <= IWAIT;
        end
        IWAIT: begin
          if (dmem_miss)       state_q <= DWAIT;
          else if (imem_ready) state_q <= RUN;
        end
        DWAIT: begin
          if (dmem_ready) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic against a
// behavioural model of the pipeline-wait rules.
module tb_hazard_ctrl;

  logic       CLK;
  logic       RST_N;
  logic [4:0] rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E;
  logic [4:0] rd_E, rd_M, rd_W;
  logic       regWrite_E, regWrite_M, regWrite_W;
  logic       memRead2_E, pc_taken_E;
  logic       imem_miss, imem_ready, dmem_miss, dmem_ready;

  logic        stall_F, stall_D, stall_E, stall_M;
  logic        flush_D, flush_E, flush_M, flush_W;
  logic [1:0]  fwdA_E, fwdB_E, dbg_state;
  logic [31:0] stall_cycles;

  logic        s_stall_F, s_stall_D, s_stall_E, s_stall_M;
  logic        s_flush_D, s_flush_E, s_flush_M, s_flush_W;
  logic [1:0]  s_fwdA_E, s_fwdB_E, s_dbg_state;
  logic [3:0]  s_stall_cycles;

  logic [11:0] obs;
  assign obs = {stall_F, stall_D, stall_E, stall_M,
                flush_D, flush_E, flush_M, flush_W, fwdA_E, fwdB_E};

  localparam logic [11:0] O_NONE  = 12'b0000_0000_0000;
  localparam logic [11:0] O_RST   = 12'b0000_1111_0000;
  localparam logic [11:0] O_LU    = 12'b1100_0100_0000;
  localparam logic [11:0] O_DW    = 12'b1111_0001_0000;
  localparam logic [11:0] O_IW    = 12'b1000_1000_0000;
  localparam logic [11:0] O_IWBR  = 12'b1110_0010_0000;
  localparam logic [11:0] O_BR    = 12'b0000_1100_0000;

  int total = 0;
  int bad   = 0;

  // Reference model: which cache we are waiting on, and stall counts.
  bit      wait_d, wait_i;
  longint  m_cnt;
  int      m_cnt4;

  hazard_ctrl #(.CNT_W(32)) u_dut (
    .CLK(CLK), .RST_N(RST_N),
    .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
    .rs1_addr_E(rs1_addr_E), .rs2_addr_E(rs2_addr_E),
    .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
    .regWrite_E(regWrite_E), .regWrite_M(regWrite_M), .regWrite_W(regWrite_W),
    .memRead2_E(memRead2_E), .pc_taken_E(pc_taken_E),
    .imem_miss(imem_miss), .imem_ready(imem_ready),
    .dmem_miss(dmem_miss), .dmem_ready(dmem_ready),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M), .flush_W(flush_W),
    .fwdA_E(fwdA_E), .fwdB_E(fwdB_E),
    .stall_cycles(stall_cycles), .dbg_state(dbg_state)
  );

  hazard_ctrl #(.CNT_W(4)) u_sat (
    .CLK(CLK), .RST_N(RST_N),
    .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
    .rs1_addr_E(rs1_addr_E), .rs2_addr_E(rs2_addr_E),
    .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
    .regWrite_E(regWrite_E), .regWrite_M(regWrite_M), .regWrite_W(regWrite_W),
    .memRead2_E(memRead2_E), .pc_taken_E(pc_taken_E),
    .imem_miss(imem_miss), .imem_ready(imem_ready),
    .dmem_miss(dmem_miss), .dmem_ready(dmem_ready),
    .stall_F(s_stall_F), .stall_D(s_stall_D), .stall_E(s_stall_E), .stall_M(s_stall_M),
    .flush_D(s_flush_D), .flush_E(s_flush_E), .flush_M(s_flush_M), .flush_W(s_flush_W),
    .fwdA_E(s_fwdA_E), .fwdB_E(s_fwdB_E),
    .stall_cycles(s_stall_cycles), .dbg_state(s_dbg_state)
  );

  // Clock and watchdog
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] fwd_model(input logic [4:0] rs);
    if (regWrite_M && rd_M != 0 && rd_M == rs) return 2'b10;
    if (regWrite_W && rd_W != 0 && rd_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [11:0] exp_out();
    logic [7:0] sf;
    if (!RST_N) return O_RST;
    if (wait_d)      sf = O_DW[11:4];
    else if (wait_i) sf = pc_taken_E ? O_IWBR[11:4] : O_IW[11:4];
    else if (pc_taken_E) sf = O_BR[11:4];
    else if (memRead2_E && regWrite_E && rd_E != 0 &&
             (rd_E == rs1_addr_D || rd_E == rs2_addr_D)) sf = O_LU[11:4];
    else sf = 8'h00;
    return {sf, fwd_model(rs1_addr_E), fwd_model(rs2_addr_E)};
  endfunction

  // One clock: advance the model with the inputs present at the edge.
  task automatic tick();
    logic [11:0] e;
    e = exp_out();
    @(posedge CLK);
    if (!RST_N) begin
      wait_d = 0; wait_i = 0; m_cnt = 0; m_cnt4 = 0;
    end else begin
      if (e[11]) begin
        if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (m_cnt4 < 15) m_cnt4 = m_cnt4 + 1;
      end
      if (wait_d) begin
        if (dmem_ready) wait_d = 0;
      end else if (dmem_miss) begin
        wait_d = 1; wait_i = 0;
      end else if (wait_i) begin
        if (imem_ready) wait_i = 0;
      end else if (imem_miss) begin
        wait_i = 1;
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    rs1_addr_D = 0; rs2_addr_D = 0; rs1_addr_E = 0; rs2_addr_E = 0;
    rd_E = 0; rd_M = 0; rd_W = 0;
    regWrite_E = 0; regWrite_M = 0; regWrite_W = 0;
    memRead2_E = 0; pc_taken_E = 0;
    imem_miss = 0; imem_ready = 0; dmem_miss = 0; dmem_ready = 0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    rs1_addr_D = 5; rd_E = 5; memRead2_E = 1; regWrite_E = 1; pc_taken_E = 1;
    dmem_miss = 1; regWrite_M = 1; rd_M = 3; rs1_addr_E = 3;
    wait_d = 0; wait_i = 0; m_cnt = 0; m_cnt4 = 0;
    @(negedge CLK);
    total++;
    if (obs !== O_RST) begin
      bad++; $display("FAIL reset_outputs: got %b want %b", obs, O_RST);
    end
    total++;
    if (stall_cycles !== 32'd0 || s_stall_cycles !== 4'd0 || dbg_state !== 2'd0) begin
      bad++; $display("FAIL reset_state: cnt=%0d cnt4=%0d state=%0d want 0/0/0",
                      stall_cycles, s_stall_cycles, dbg_state);
    end
    tick();
    clear_inputs();
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    memRead2_E = 1; regWrite_E = 1; rd_E = 5; rs1_addr_D = 5;
    @(negedge CLK);
    total++;
    if (obs !== O_LU) begin bad++; $display("FAIL load_use_stall: got %b want %b", obs, O_LU); end
    tick();
    // Bubble now in E, load moved to M, consumer still in D.
    memRead2_E = 0; regWrite_E = 0; rd_E = 0; regWrite_M = 1; rd_M = 5;
    @(negedge CLK);
    total++;
    if (obs !== O_NONE) begin bad++; $display("FAIL load_use_one_bubble: got %b want %b", obs, O_NONE); end
    tick();
    clear_inputs();
    memRead2_E = 1; regWrite_E = 1; rd_E = 0; rs1_addr_D = 0; rs2_addr_D = 0;
    @(negedge CLK);
    total++;
    if (obs !== O_NONE) begin bad++; $display("FAIL load_use_x0: got %b want %b", obs, O_NONE); end
    tick();
    clear_inputs();
    memRead2_E = 1; regWrite_E = 1; rd_E = 9; rs2_addr_D = 9;
    @(negedge CLK);
    total++;
    if (obs !== O_LU) begin bad++; $display("FAIL load_use_rs2: got %b want %b", obs, O_LU); end
    tick();
    clear_inputs();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    rd_M = 7; rd_W = 7; regWrite_M = 1; regWrite_W = 1; rs1_addr_E = 7; rs2_addr_E = 3;
    @(negedge CLK);
    total++;
    if (fwdA_E !== 2'b10 || fwdB_E !== 2'b00) begin
      bad++; $display("FAIL fwd_from_m: got A=%b B=%b want A=10 B=00", fwdA_E, fwdB_E);
    end
    tick();
    regWrite_M = 0;
    @(negedge CLK);
    total++;
    if (fwdA_E !== 2'b01) begin bad++; $display("FAIL fwd_from_w: got %b want 01", fwdA_E); end
    tick();
    rd_M = 0; rd_W = 0; regWrite_M = 1; regWrite_W = 1; rs1_addr_E = 0; rs2_addr_E = 0;
    @(negedge CLK);
    total++;
    if (fwdA_E !== 2'b00 || fwdB_E !== 2'b00) begin
      bad++; $display("FAIL fwd_x0: got A=%b B=%b want 00 00", fwdA_E, fwdB_E);
    end
    tick();
    rd_M = 4; rd_W = 6; rs1_addr_E = 6; rs2_addr_E = 4;
    @(negedge CLK);
    total++;
    if (fwdA_E !== 2'b01 || fwdB_E !== 2'b10) begin
      bad++; $display("FAIL fwd_mixed: got A=%b B=%b want 01 10", fwdA_E, fwdB_E);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_dmiss();
    int     stalls;
    longint cnt_start;
    clear_inputs();
    cnt_start = m_cnt;
    stalls = 0;
    dmem_miss = 1;
    @(negedge CLK);
    total++;
    if (obs !== O_NONE) begin bad++; $display("FAIL dmiss_entry: got %b want %b", obs, O_NONE); end
    tick();
    for (int c = 0; c < 11; c++) begin
      if (c == 10) begin dmem_miss = 0; dmem_ready = 1; end
      @(negedge CLK);
      if (stall_F) stalls++;
      total++;
      if (obs !== O_DW) begin bad++; $display("FAIL dmiss_wait c%0d: got %b want %b", c, obs, O_DW); end
      tick();
    end
    dmem_ready = 0;
    @(negedge CLK);
    total++;
    if (obs !== O_NONE || dbg_state !== 2'd0) begin
      bad++; $display("FAIL dmiss_resume: got %b st=%0d want %b st=0", obs, dbg_state, O_NONE);
    end
    total++;
    if (stalls != 11 || stall_cycles !== 32'(cnt_start + 11)) begin
      bad++; $display("FAIL dmiss_count: stalls=%0d cnt=%0d want 11 and %0d",
                      stalls, stall_cycles, cnt_start + 11);
    end
    tick();
  endtask

  task automatic test_imiss_branch();
    logic [11:0] want;
    clear_inputs();
    imem_miss = 1;
    tick();
    for (int c = 1; c <= 7; c++) begin
      pc_taken_E = (c >= 3);
      if (c == 6) begin imem_miss = 0; imem_ready = 1; end
      if (c == 7) imem_ready = 0;
      want = (c == 7) ? O_BR : (c >= 3) ? O_IWBR : O_IW;
      @(negedge CLK);
      total++;
      if (obs !== want) begin bad++; $display("FAIL imiss_branch c%0d: got %b want %b", c, obs, want); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_overlap();
    logic [11:0] want;
    logic [1:0]  want_st;
    clear_inputs();
    imem_miss = 1; dmem_miss = 1;
    tick();
    for (int c = 1; c <= 11; c++) begin
      if (c == 5) begin dmem_miss = 0; dmem_ready = 1; end
      if (c == 6) dmem_ready = 0;
      if (c == 10) begin imem_miss = 0; imem_ready = 1; end
      if (c == 11) imem_ready = 0;
      if (c <= 5)       begin want = O_DW;   want_st = 2'd2; end
      else if (c == 6)  begin want = O_NONE; want_st = 2'd0; end
      else if (c <= 10) begin want = O_IW;   want_st = 2'd1; end
      else              begin want = O_NONE; want_st = 2'd0; end
      @(negedge CLK);
      total++;
      if (obs !== want || dbg_state !== want_st) begin
        bad++; $display("FAIL overlap c%0d: got %b st=%0d want %b st=%0d", c, obs, dbg_state, want, want_st);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_dwait();
    clear_inputs();
    dmem_miss = 1;
    tick();
    tick();
    tick();
    RST_N = 1'b0;
    wait_d = 0; wait_i = 0; m_cnt = 0; m_cnt4 = 0;
    #1;
    total++;
    if (obs !== O_RST || dbg_state !== 2'd0 || stall_cycles !== 32'd0 || s_stall_cycles !== 4'd0) begin
      bad++; $display("FAIL reset_mid_dwait: got %b st=%0d cnt=%0d want %b st=0 cnt=0",
                      obs, dbg_state, stall_cycles, O_RST);
    end
    tick();
    clear_inputs();
    RST_N = 1'b1;
    @(negedge CLK);
    total++;
    if (obs !== O_NONE) begin bad++; $display("FAIL reset_abandons_miss: got %b want %b", obs, O_NONE); end
    tick();
  endtask

  task automatic test_saturation();
    clear_inputs();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    dmem_miss = 1;
    for (int c = 0; c < 21; c++) tick();
    @(negedge CLK);
    total++;
    if (s_stall_cycles !== 4'd15 || stall_cycles !== 32'd20) begin
      bad++; $display("FAIL counter_saturate: cnt4=%0d cnt32=%0d want 15 20", s_stall_cycles, stall_cycles);
    end
    dmem_miss = 0; dmem_ready = 1;
    tick();
    dmem_ready = 0;
    tick();
    @(negedge CLK);
    total++;
    if (s_stall_cycles !== 4'd15 || stall_cycles !== 32'd21) begin
      bad++; $display("FAIL counter_hold: cnt4=%0d cnt32=%0d want 15 21", s_stall_cycles, stall_cycles);
    end
    tick();
  endtask

  task automatic test_random();
    logic [11:0] e;
    for (int c = 0; c < 1500; c++) begin
      rs1_addr_D = 5'($urandom_range(0, 3)); rs2_addr_D = 5'($urandom_range(0, 3));
      rs1_addr_E = 5'($urandom_range(0, 3)); rs2_addr_E = 5'($urandom_range(0, 3));
      rd_E = 5'($urandom_range(0, 3)); rd_M = 5'($urandom_range(0, 3)); rd_W = 5'($urandom_range(0, 3));
      regWrite_E = 1'($urandom_range(0, 1)); regWrite_M = 1'($urandom_range(0, 1));
      regWrite_W = 1'($urandom_range(0, 1)); memRead2_E = 1'($urandom_range(0, 1));
      pc_taken_E = ($urandom_range(0, 3) == 0);
      imem_miss  = ($urandom_range(0, 3) == 0); imem_ready = ($urandom_range(0, 4) == 0);
      dmem_miss  = ($urandom_range(0, 5) == 0); dmem_ready = ($urandom_range(0, 4) == 0);
      @(negedge CLK);
      e = exp_out();
      total++;
      if (obs !== e || stall_cycles !== 32'(m_cnt) || s_stall_cycles !== 4'(m_cnt4)) begin
        bad++; $display("FAIL random c%0d: got %b cnt=%0d cnt4=%0d want %b cnt=%0d cnt4=%0d",
                        c, obs, stall_cycles, s_stall_cycles, e, m_cnt, m_cnt4);
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    RST_N = 1'b0;
    #2;
    test_reset();
    test_load_use();
    test_forwarding();
    test_dmiss();
    test_imiss_branch();
    test_overlap();
    test_reset_mid_dwait();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
